asic_frame_packer: RTL and testbench
====================================

Name: asic_frame_packer

Overview:
- Downstream of the ASIC RAM deserializer. Drains the 16-bit words it writes into the external FIFO.
- Groups the words into fixed-length ASIC frames (10 words = 160 bits per HARDROC event).
- Wraps one readout cycle in header and trailer words and hands the stream to the USB/output FIFO over a valid/ready handshake.
- Reports frame count and a truncated-frame error.

Parameters:
- WORDS_PER_FRAME, 10, words per ASIC event frame (range 2..15).
- HEADER_WORD, 16'hA5A5, first word of every packet.
- TRAILER_WORD, 16'h5A5A, last word of every packet.
- DIF_ID, 8'h01, board identifier placed in the header ID word.

Ports:
- Clk  in  1  system clock, 40 MHz.
- reset  in  1  synchronous, active-high reset.
- StartReadout  in  1  one-cycle pulse; ASIC readout cycle begins.
- ReadoutDone  in  1  one-cycle pulse; ASIC TransmitOn has returned inactive, no more words will be written.
- FifoDout  in  16  external FIFO read data, valid one cycle after FifoRdEn.
- FifoEmpty  in  1  external FIFO empty.
- FifoRdEn  out  1  external FIFO read strobe.
- OutData  out  16  packet word.
- OutValid  out  1  OutData valid.
- OutReady  in  1  downstream accepts; a transfer happens when OutValid && OutReady.
- FrameCount  out  12  complete frames in current/last packet.
- FrameError  out  1  last packet ended with a partial frame (sticky until next StartReadout).
- Busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, active-high): state IDLE; FifoRdEn=0, OutValid=0, OutData=0, FrameCount=0, FrameError=0, Busy=0, word index=0, done latch=0.
- Output register: OutData/OutValid hold steady until accepted. New word loads only when OutValid=0 or the current word is accepted in the same cycle.
- FIFO read rule:
  - FifoRdEn=1 only in DATA, when ~FifoEmpty, no read is outstanding, and the output register is free.
  - Returned word loads into the output register the next cycle.
  - Sustained throughput is therefore at most 1 word per 2 cycles (ASIC rate is 1 word per 128 cycles).
- States:
  - IDLE: StartReadout -> HDR0. Clear FrameCount, FrameError, done latch.
  - HDR0: present HEADER_WORD; on accept -> HDR1.
  - HDR1: present {DIF_ID, 8'h00}; on accept -> DATA.
  - DATA: forward FIFO words.
    - Word index increments per accepted data word.
    - At WORDS_PER_FRAME-1 the index wraps to 0 and FrameCount increments; FrameCount saturates at 12'hFFF.
    - ReadoutDone sets the done latch; a pulse arriving in HDR0/HDR1 also sets it.
    - Exit when done latch=1, FifoEmpty=1, no read outstanding, output register empty:
      - word index=0 -> TRL1 (or CRC, see Optional Feature).
      - word index!=0 -> PAD.
  - PAD: present 16'h0000 words until the index wraps. Set FrameError=1. FrameCount does not increment for the padded frame. Then -> TRL1 (or CRC).
  - TRL1: present {4'h0, FrameCount}; on accept -> TRL0.
  - TRL0: present TRAILER_WORD; on accept -> IDLE.
- StartReadout while Busy: ignored.
- ReadoutDone in IDLE: ignored.
- FIFO words arriving after done latch but before empty: still forwarded.
- Simultaneous ReadoutDone and final FIFO read: the word is forwarded before exit.
- OutReady low for arbitrary time: no word lost or duplicated, FifoRdEn held 0.
- reset mid-packet: immediate return to IDLE. The partial packet is abandoned and no trailer is sent. The FIFO is not flushed.

Optional Feature:
- Macro FRAME_CRC_EN.
- Defined: a CRC-16-CCITT (poly 16'h1021, init 16'hFFFF, MSB first) runs over all data and pad words of the packet. A CRC state presents the CRC word between the last data/pad word and TRL1.
- Undefined: no CRC state, no CRC logic; the packet ends directly with TRL1, TRL0.

Decomposition:
- Shared package: state encoding localparams; HEADER_WORD/TRAILER_WORD defaults; CRC polynomial and init constants.
- One natural sub-module, crc16_step: combinational 16-bit-word CRC update. Instantiated only under FRAME_CRC_EN.

Test Plan:
- StartReadout, 20 words preloaded, ReadoutDone, OutReady=1 -> A5A5, 0100, 20 words in order, 0002, 5A5A; FrameCount=2, FrameError=0.
- 13 words then ReadoutDone -> 10 words, 3 words + 7 x 0000, 0001, 5A5A; FrameError=1.
- Same as first scenario with OutReady toggling 1-of-3 cycles -> identical word sequence, no duplicates, FifoRdEn never high while OutValid && ~OutReady.
- StartReadout then immediate ReadoutDone, FIFO empty -> A5A5, 0100, 0000, 5A5A; FrameCount=0.
- reset asserted after 5 data words, then new StartReadout -> outputs zero for one cycle, new packet starts with A5A5, FrameCount restarts at 0.
- FRAME_CRC_EN defined, 10 words 0x0001..0x000A -> CRC word equals reference-model CRC-16-CCITT, placed before 0001, 5A5A.

Source files
------------

// File: rtl/asic_frame_packer_pkg.sv
// Shared constants for the ASIC frame packer: state encoding, default packet words, CRC constants.
package asic_frame_packer_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR0 = 3'd1;
  localparam logic [2:0] ST_HDR1 = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_PAD  = 3'd4;
  localparam logic [2:0] ST_CRC  = 3'd5;
  localparam logic [2:0] ST_TRL1 = 3'd6;
  localparam logic [2:0] ST_TRL0 = 3'd7;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    HDR0 = ST_HDR0,
    HDR1 = ST_HDR1,
    DATA = ST_DATA,
    PAD  = ST_PAD,
    CRC  = ST_CRC,
    TRL1 = ST_TRL1,
    TRL0 = ST_TRL0
  } state_t;

  localparam logic [15:0] HEADER_WORD_DEFAULT  = 16'hA5A5;
  localparam logic [15:0] TRAILER_WORD_DEFAULT = 16'h5A5A;
  localparam logic [7:0]  DIF_ID_DEFAULT       = 8'h01;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/asic_frame_packer_crc16_step.sv
// One 16-bit word of CRC-16-CCITT, processed MSB first, purely combinational.
module asic_frame_packer_crc16_step
  import asic_frame_packer_pkg::*;
(
  input  logic [15:0] crc,
  input  logic [15:0] data,
  output logic [15:0] crc_next
);

  always_comb begin
    crc_next = crc;
    for (int i = 15; i >= 0; i--) begin
      if (crc_next[15] ^ data[i]) begin
        crc_next = {crc_next[14:0], 1'b0} ^ CRC_POLY;
      end else begin
        crc_next = {crc_next[14:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/asic_frame_packer.sv
// Drains deserialized ASIC words into header / fixed-length frames / trailer packets on a valid/ready stream.
// Optional macro FRAME_CRC_EN inserts a CRC-16-CCITT word over the payload before the frame-count trailer.
module asic_frame_packer
  import asic_frame_packer_pkg::*;
#(
  parameter int          WORDS_PER_FRAME = 10,
  parameter logic [15:0] HEADER_WORD     = HEADER_WORD_DEFAULT,
  parameter logic [15:0] TRAILER_WORD    = TRAILER_WORD_DEFAULT,
  parameter logic [7:0]  DIF_ID          = DIF_ID_DEFAULT
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        StartReadout,
  input  logic        ReadoutDone,
  input  logic [15:0] FifoDout,
  input  logic        FifoEmpty,
  output logic        FifoRdEn,
  output logic [15:0] OutData,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [11:0] FrameCount,
  output logic        FrameError,
  output logic        Busy
);

  localparam logic [3:0] LAST_IDX = 4'(WORDS_PER_FRAME - 1);

  state_t      state;
  logic [3:0]  word_idx;
  logic        done_latch;
  logic        rd_pending;
  logic        accept;
  logic        out_free;
  logic        idx_last;
  logic        drain_done;
  state_t      tail_state;
  logic [15:0] tail_word;

  assign accept     = OutValid && OutReady;
  assign out_free   = !OutValid || OutReady;
  assign idx_last   = (word_idx == LAST_IDX);
  assign drain_done = done_latch && FifoEmpty && !rd_pending && !OutValid;
  assign FifoRdEn   = (state == DATA) && !FifoEmpty && !rd_pending && out_free;
  assign Busy       = (state != IDLE);

`ifdef FRAME_CRC_EN
  logic [15:0] crc;
  logic [15:0] crc_next;
  logic [15:0] crc_word;

  assign crc_word = (state == PAD) ? 16'h0000 : FifoDout;

  asic_frame_packer_crc16_step u_crc_step (
    .crc      (crc),
    .data     (crc_word),
    .crc_next (crc_next)
  );

  // CRC advances exactly when a payload word enters the output register.
  always_ff @(posedge Clk) begin
    if (reset || state == IDLE) begin
      crc <= CRC_INIT;
    end else if ((state == DATA && rd_pending) || (state == PAD && !OutValid)) begin
      crc <= crc_next;
    end
  end

  assign tail_state = CRC;
  assign tail_word  = crc;
`else
  assign tail_state = TRL1;
  assign tail_word  = {4'h0, FrameCount};
`endif

  always_ff @(posedge Clk) begin
    if (reset) begin
      state      <= IDLE;
      OutData    <= 16'h0000;
      OutValid   <= 1'b0;
      FrameCount <= 12'h000;
      FrameError <= 1'b0;
      word_idx   <= 4'd0;
      done_latch <= 1'b0;
      rd_pending <= 1'b0;
    end else begin
      // Each state reloads the output register when it has more to say.
      if (accept) OutValid <= 1'b0;
      rd_pending <= FifoRdEn;
      if (ReadoutDone && (state == HDR0 || state == HDR1 || state == DATA)) done_latch <= 1'b1;

      case (state)
        IDLE: begin
          if (StartReadout) begin
            state      <= HDR0;
            FrameCount <= 12'h000;
            FrameError <= 1'b0;
            done_latch <= 1'b0;
            word_idx   <= 4'd0;
            OutData    <= HEADER_WORD;
            OutValid   <= 1'b1;
          end
        end
        HDR0: begin
          if (accept) begin
            OutData  <= {DIF_ID, 8'h00};
            OutValid <= 1'b1;
            state    <= HDR1;
          end
        end
        HDR1: begin
          if (accept) state <= DATA;
        end
        DATA: begin
          if (rd_pending) begin
            OutData  <= FifoDout;
            OutValid <= 1'b1;
          end
          if (accept) begin
            word_idx <= idx_last ? 4'd0 : word_idx + 4'd1;
            if (idx_last && FrameCount != 12'hFFF) FrameCount <= FrameCount + 12'd1;
          end
          if (drain_done) begin
            if (word_idx == 4'd0) begin
              state    <= tail_state;
              OutData  <= tail_word;
              OutValid <= 1'b1;
            end else begin
              state      <= PAD;
              FrameError <= 1'b1;
            end
          end
        end
        PAD: begin
          if (!OutValid) begin
            OutData  <= 16'h0000;
            OutValid <= 1'b1;
          end
          if (accept) begin
            if (idx_last) begin
              word_idx <= 4'd0;
              state    <= tail_state;
              OutData  <= tail_word;
              OutValid <= 1'b1;
            end else begin
              word_idx <= word_idx + 4'd1;
            end
          end
        end
`ifdef FRAME_CRC_EN
        CRC: begin
          if (accept) begin
            OutData  <= {4'h0, FrameCount};
            OutValid <= 1'b1;
            state    <= TRL1;
          end
        end
`endif
        TRL1: begin
          if (accept) begin
            OutData  <= TRAILER_WORD;
            OutValid <= 1'b1;
            state    <= TRL0;
          end
        end
        TRL0: begin
          if (accept) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_asic_frame_packer.sv
// Scoreboard bench for asic_frame_packer: packets predicted from word counts, checked by a stream monitor.
module tb_asic_frame_packer;

  localparam int W = 10;

  logic        Clk = 1'b0;
  logic        reset;
  logic        StartReadout;
  logic        ReadoutDone;
  logic [15:0] FifoDout = 16'h0000;
  logic        FifoEmpty;
  logic        FifoRdEn;
  logic [15:0] OutData;
  logic        OutValid;
  logic        OutReady;
  logic [11:0] FrameCount;
  logic        FrameError;
  logic        Busy;

  logic [15:0] fifo_mem [0:1023];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic [15:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          accepted = 0;

  asic_frame_packer dut (
    .Clk          (Clk),
    .reset        (reset),
    .StartReadout (StartReadout),
    .ReadoutDone  (ReadoutDone),
    .FifoDout     (FifoDout),
    .FifoEmpty    (FifoEmpty),
    .FifoRdEn     (FifoRdEn),
    .OutData      (OutData),
    .OutValid     (OutValid),
    .OutReady     (OutReady),
    .FrameCount   (FrameCount),
    .FrameError   (FrameError),
    .Busy         (Busy)
  );

  always #5 Clk = ~Clk;

  // External FIFO: read data appears the cycle after the strobe.
  assign FifoEmpty = (wr_ptr == rd_ptr);
  always @(posedge Clk) begin
    if (FifoRdEn && !FifoEmpty) begin
      FifoDout <= fifo_mem[rd_ptr % 1024];
      rd_ptr   <= rd_ptr + 1;
    end
  end

  function automatic void checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endfunction

`ifdef FRAME_CRC_EN
  function automatic logic [15:0] crcModel(logic [15:0] words [$]);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (words[k]) begin
      for (int b = 15; b >= 0; b--) begin
        fb = c[15] ^ words[k][b];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    end
    return c;
  endfunction
`endif

  // Monitor: every accepted word is popped from the scoreboard.
  always @(negedge Clk) begin
    if (!reset) begin
      if (OutValid && !OutReady) checkOutput("rden_while_stalled", 32'(FifoRdEn), 32'd0);
      if (OutValid && OutReady) begin
        accepted++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: got %h with no word expected", OutData);
        end else begin
          checkOutput("out_word", 32'(OutData), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic applyStimulus(input int n, input int ready_mode, input bit trickle,
                               input bit seq, input bit poke);
    logic [15:0] words [$];
    logic [15:0] pay [$];
    int          pushed;
    int          cyc;
    int          pad;
    bit          done_sent;
    for (int i = 0; i < n; i++) words.push_back(seq ? 16'(i + 1) : 16'($urandom));
    pay = words;
    pad = (n % W == 0) ? 0 : W - (n % W);
    for (int i = 0; i < pad; i++) pay.push_back(16'h0000);
    exp_q.push_back(16'hA5A5);
    exp_q.push_back(16'h0100);
    foreach (pay[k]) exp_q.push_back(pay[k]);
`ifdef FRAME_CRC_EN
    exp_q.push_back(crcModel(pay));
`endif
    exp_q.push_back({4'h0, 12'(n / W)});
    exp_q.push_back(16'h5A5A);

    pushed = 0;
    if (!trickle) begin
      foreach (words[k]) begin
        fifo_mem[wr_ptr % 1024] = words[k];
        wr_ptr++;
      end
      pushed = n;
    end
    StartReadout = 1'b1;
    @(posedge Clk); #1;
    StartReadout = 1'b0;
    done_sent = 1'b0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      case (ready_mode)
        0:       OutReady = 1'b1;
        1:       OutReady = (cyc % 3 == 0);
        default: OutReady = 1'($urandom_range(0, 1));
      endcase
      if (trickle && pushed < n && $urandom_range(0, 2) == 0) begin
        fifo_mem[wr_ptr % 1024] = words[pushed];
        wr_ptr++;
        pushed++;
      end
      if (!done_sent && pushed == n) begin
        ReadoutDone = 1'b1;
        done_sent   = 1'b1;
      end
      StartReadout = poke && (cyc == 5);
      @(posedge Clk); #1;
      ReadoutDone  = 1'b0;
      StartReadout = 1'b0;
      if (done_sent && !Busy) break;
    end
    if (cyc >= 3000) begin
      checks++;
      errors++;
      $display("[TB] FAIL packet_timeout: got busy after %0d cycles expected idle", cyc);
    end
    checkOutput("frame_count", 32'(FrameCount), 32'(n / W));
    checkOutput("frame_error", 32'(FrameError), 32'(n % W != 0));
    checkOutput("packet_drained", 32'(exp_q.size()), 32'd0);
    OutReady = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic resetMidPacket();
    int base;
    int cyc;
    exp_q.push_back(16'hA5A5);
    exp_q.push_back(16'h0100);
    for (int i = 0; i < 20; i++) begin
      fifo_mem[wr_ptr % 1024] = 16'(16'h3000 + i);
      exp_q.push_back(16'(16'h3000 + i));
      wr_ptr++;
    end
    base = accepted;
    StartReadout = 1'b1;
    OutReady     = 1'b1;
    @(posedge Clk); #1;
    StartReadout = 1'b0;
    for (cyc = 0; cyc < 500 && accepted < base + 7; cyc++) begin
      @(posedge Clk); #1;
    end
    checkOutput("reset_mid_reached", 32'(accepted - base >= 7), 32'd1);
    reset    = 1'b1;
    OutReady = 1'b0;
    @(posedge Clk); #1;
    reset = 1'b0;
    checkOutput("after_reset_valid", 32'(OutValid), 32'd0);
    checkOutput("after_reset_data", 32'(OutData), 32'd0);
    checkOutput("after_reset_busy", 32'(Busy), 32'd0);
    checkOutput("after_reset_count", 32'(FrameCount), 32'd0);
    checkOutput("after_reset_rden", 32'(FifoRdEn), 32'd0);
    exp_q.delete();
    wr_ptr = rd_ptr;
  endtask

  initial begin
    reset        = 1'b1;
    StartReadout = 1'b0;
    ReadoutDone  = 1'b0;
    OutReady     = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    checkOutput("reset_valid", 32'(OutValid), 32'd0);
    checkOutput("reset_data", 32'(OutData), 32'd0);
    checkOutput("reset_count", 32'(FrameCount), 32'd0);
    checkOutput("reset_error", 32'(FrameError), 32'd0);
    checkOutput("reset_busy", 32'(Busy), 32'd0);
    checkOutput("reset_rden", 32'(FifoRdEn), 32'd0);
    reset = 1'b0;

    ReadoutDone = 1'b1;
    @(posedge Clk); #1;
    ReadoutDone = 1'b0;
    @(posedge Clk); #1;
    checkOutput("done_in_idle_busy", 32'(Busy), 32'd0);

    applyStimulus(20, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(13, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(20, 1, 1'b0, 1'b0, 1'b0);
    applyStimulus(0,  0, 1'b0, 1'b0, 1'b0);
    resetMidPacket();
    applyStimulus(20, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(10, 0, 1'b0, 1'b1, 1'b0);
    applyStimulus(25, 2, 1'b1, 1'b0, 1'b1);
    for (int s = 0; s < 6; s++) begin
      applyStimulus(int'($urandom_range(0, 35)), int'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
